// File: rtl/data_register_bank_pkg.sv
// Shared types and helpers for data_register_bank (package data_reg_pkg).
// DATA_REG_SATURATE_EN selects saturating accumulate instead of modulo wrap.
package data_reg_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_DEPTH = 8;

   typedef enum logic {
      IDLE     = 1'b0,
      CLEARING = 1'b1
   } state_e;

   // High when the accumulate result must be pinned to all-ones.
   function automatic logic sat_select(input logic carry);
`ifdef DATA_REG_SATURATE_EN
      return carry;
`else
      return carry & 1'b0;
`endif
   endfunction

endpackage

// File: rtl/data_register_bank_if.sv
// Write/accumulate/read/clear bus between a MAC core and its data_register_bank.
interface data_register_bank_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
);
   localparam int AW = $clog2(DEPTH);

   logic             write;
   logic             acc;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] data_in;
   logic [AW-1:0]    raddr;
   logic [WIDTH-1:0] data_out;
   logic             clear;
   logic             busy;
   logic             ovf;

   modport master (
      output write, acc, waddr, data_in, raddr, clear,
      input  data_out, busy, ovf
   );

   modport slave (
      input  write, acc, waddr, data_in, raddr, clear,
      output data_out, busy, ovf
   );
endinterface

// File: rtl/data_register_bank_acc_unit.sv
// Combinational WIDTH-bit adder with carry-out; saturates on carry when
// DATA_REG_SATURATE_EN is defined, otherwise wraps.
module data_reg_acc_unit
   import data_reg_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);
   logic [WIDTH-1:0] raw;

   assign {carry, raw} = {1'b0, a} + {1'b0, b};
   assign sum          = sat_select(carry) ? {WIDTH{1'b1}} : raw;

endmodule

// File: rtl/data_register_bank.sv
// DEPTH x WIDTH register bank with load, accumulate-in-place and a one-entry-
// per-cycle clear sequence. DATA_REG_SATURATE_EN selects saturating accumulate.
module data_register_bank
   import data_reg_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                 clk,
   input  logic                 rst,
   data_register_bank_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
   state_e                      st_q, st_d;
   logic [AW-1:0]               ptr_q, ptr_d;
   logic                        busy_q, busy_d;
   logic                        ovf_q, ovf_d;
   logic [WIDTH-1:0]            dout_q, dout_d;
   logic [WIDTH-1:0]            acc_sum;
   logic                        acc_carry;

   // Operand comes straight from the flops, so back-to-back accumulates chain.
   data_reg_acc_unit #(.WIDTH(WIDTH)) u_acc (
      .a     (mem_q[bus.waddr]),
      .b     (bus.data_in),
      .sum   (acc_sum),
      .carry (acc_carry)
   );

   always_comb begin
      st_d   = st_q;
      ptr_d  = ptr_q;
      mem_d  = mem_q;
      ovf_d  = 1'b0;
      dout_d = mem_q[bus.raddr];
      unique case (st_q)
         IDLE: begin
            if (bus.write) begin
               mem_d[bus.waddr] = bus.data_in;
            end else if (bus.acc) begin
               mem_d[bus.waddr] = acc_sum;
               ovf_d            = acc_carry;
            end
            if (bus.clear) begin
               st_d  = CLEARING;
               ptr_d = '0;
            end
         end
         CLEARING: begin
            mem_d[ptr_q] = '0;
            ptr_d        = ptr_q + 1'b1;
            if (ptr_q == AW'(DEPTH - 1)) st_d = IDLE;
         end
         default: st_d = IDLE;
      endcase
      busy_d = (st_d == CLEARING);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q  <= '0;
         st_q   <= IDLE;
         ptr_q  <= '0;
         busy_q <= 1'b0;
         ovf_q  <= 1'b0;
         dout_q <= '0;
      end else begin
         mem_q  <= mem_d;
         st_q   <= st_d;
         ptr_q  <= ptr_d;
         busy_q <= busy_d;
         ovf_q  <= ovf_d;
         dout_q <= dout_d;
      end
   end

   assign bus.data_out = dout_q;
   assign bus.busy     = busy_q;
   assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_data_register_bank.sv
// Directed bench for data_register_bank: read results checked through an
// expected-value queue, control outputs checked inline.
module tb_data_register_bank;
   localparam int WIDTH = 16;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vec_cnt = 0;
   int   err_cnt = 0;
   logic [WIDTH-1:0] exp_q[$];

   data_register_bank_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   data_register_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_in();
      bus.write = 1'b0; bus.acc = 1'b0; bus.clear = 1'b0;
   endtask

   task automatic wr(input int a, input logic [WIDTH-1:0] d);
      bus.write = 1'b1; bus.acc = 1'b0; bus.waddr = 3'(a); bus.data_in = d;
      cyc();
      idle_in();
   endtask

   // Expected read value is queued with the request and popped once data_out is valid.
   task automatic rd(input string tag, input int a, input logic [WIDTH-1:0] e);
      bus.raddr = 3'(a);
      exp_q.push_back(e);
      cyc();
      chk(tag, bus.data_out, exp_q.pop_front());
   endtask

   task automatic fill();
      for (int i = 0; i < DEPTH; i++) wr(i, WIDTH'(i * 16'h1111 + 1));
   endtask

   initial begin
      logic [WIDTH-1:0] sat_exp;
      int n;
      idle_in();
      bus.waddr = '0; bus.raddr = '0; bus.data_in = '0;

      #2;
      chk("rst_data_out", bus.data_out, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_ovf", bus.ovf, 0);
      #10 rst = 1'b1;
      cyc();

      // Plain write and read-back, other entries untouched
      wr(3, 16'h2445);
      rd("rd_a3", 3, 16'h2445);
      for (int i = 0; i < DEPTH; i++) if (i != 3) rd("rd_zero", i, 16'h0000);

      // Accumulate with carry-out
`ifdef DATA_REG_SATURATE_EN
      sat_exp = 16'hFFFF;
`else
      sat_exp = 16'h0010;
`endif
      wr(1, 16'hFFF0);
      bus.acc = 1'b1; bus.waddr = 3'd1; bus.data_in = 16'h0020;
      cyc();
      idle_in();
      chk("ovf_pulse", bus.ovf, 1);
      cyc();
      chk("ovf_one_cycle", bus.ovf, 0);
      rd("acc_carry_val", 1, sat_exp);

      // Back-to-back accumulates chain without carry
      for (int k = 0; k < 3; k++) begin
         bus.acc = 1'b1; bus.waddr = 3'd2; bus.data_in = 16'h0005;
         cyc();
         chk("ovf_chain", bus.ovf, 0);
      end
      idle_in();
      rd("acc_chain_val", 2, 16'h000F);

      // write beats acc
      bus.write = 1'b1; bus.acc = 1'b1; bus.waddr = 3'd0; bus.data_in = 16'hE5C5;
      cyc();
      idle_in();
      chk("wr_acc_ovf", bus.ovf, 0);
      rd("wr_acc_val", 0, 16'hE5C5);

      // Read-before-write on the same address
      bus.raddr = 3'd0; exp_q.push_back(16'hE5C5);
      bus.write = 1'b1; bus.waddr = 3'd0; bus.data_in = 16'h1357;
      cyc();
      idle_in();
      chk("rbw_old", bus.data_out, exp_q.pop_front());
      rd("rbw_new", 0, 16'h1357);

      // Full clear; writes and accumulates during busy must be dropped
      fill();
      bus.clear = 1'b1;
      cyc();
      bus.clear = 1'b0;
      chk("clear_busy_start", bus.busy, 1);
      n = 0;
      while (bus.busy === 1'b1 && n < 20) begin
         n++;
         bus.write = n[0]; bus.acc = ~n[0]; bus.clear = 1'b1;
         bus.waddr = 3'd0; bus.data_in = 16'h1234;
         cyc();
         chk("clear_ovf", bus.ovf, 0);
      end
      idle_in();
      chk("clear_busy_cycles", n, DEPTH);
      for (int i = 0; i < DEPTH; i++) rd("clear_zero", i, 16'h0000);

      // Reset mid-clear at ptr==3
      fill();
      bus.raddr = 3'd6;
      bus.clear = 1'b1;
      cyc();
      bus.clear = 1'b0;
      cyc(); cyc(); cyc();
      chk("midclr_busy", bus.busy, 1);
      chk("midclr_dout", bus.data_out, 32'(16'h6667));
      rst = 1'b0;
      #1;
      chk("midclr_rst_busy", bus.busy, 0);
      chk("midclr_rst_dout", bus.data_out, 0);
      #2 rst = 1'b1;
      cyc();
      chk("post_rst_busy", bus.busy, 0);
      wr(4, 16'h5A5A);
      for (int i = 0; i < DEPTH; i++) rd("post_rst_rd", i, (i == 4) ? 16'h5A5A : 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
